// File: rtl/speculation_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : speculation_controller_pkg
// Description : Shared state encoding and default sizing for the speculation
//               controller and its shadow-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package speculation_controller_pkg;

    localparam int c_DEFAULT_REGCOUNT        = 16;
    localparam int c_DEFAULT_REGADDRBITWIDTH = $clog2(c_DEFAULT_REGCOUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPEC  = 2'd1,
        FLUSH = 2'd2
    } specState_t;

endpackage
`default_nettype wire

// File: rtl/speculation_controller_shadow_mask.sv
`default_nettype none
// ============================================================================
// Module      : SpeculationShadowMask
// Description : Per-cell "already shadowed" mask plus the write-address decode
//               that produces the shadow-capture strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module SpeculationShadowMask
    import speculation_controller_pkg::*;
#(
    parameter int REGCOUNT        = c_DEFAULT_REGCOUNT,
    parameter int REGADDRBITWIDTH = c_DEFAULT_REGADDRBITWIDTH
) (
    input  logic                       clk,
    input  logic                       async_rst,
    input  logic                       clk_en,
    input  logic                       inSpec,
    input  logic                       clearMask,
    input  logic                       BranchResolveValid,
    input  logic                       IssueWriteValid,
    input  logic [REGADDRBITWIDTH-1:0] IssueWriteAddr,
    output logic [REGCOUNT-1:0]        WillBeWritingToA
);

    logic [REGCOUNT-1:0] r_shadowTaken;

    // Addresses at or above REGCOUNT match no cell and so raise no strobe.
    generate
        for (genvar i = 0; i < REGCOUNT; i++) begin : g_cell
            assign WillBeWritingToA[i] = inSpec
                                      && IssueWriteValid
                                      && (IssueWriteAddr == REGADDRBITWIDTH'(i))
                                      && !r_shadowTaken[i]
                                      && !BranchResolveValid;
        end
    endgenerate

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_shadowTaken <= '0;
        end else if (clk_en) begin
            if (clearMask) begin
                r_shadowTaken <= '0;
            end else begin
                r_shadowTaken <= r_shadowTaken | WillBeWritingToA;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/speculation_controller.sv
`default_nettype none
// ============================================================================
// Module      : speculation_controller
// Description : Single-level branch speculation FSM driving register-file
//               shadow capture, commit and restore broadcasts.
//               Optional macro SPECULATION_PERF_COUNTERS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
module speculation_controller
    import speculation_controller_pkg::*;
#(
    parameter int REGCOUNT        = c_DEFAULT_REGCOUNT,
    parameter int REGADDRBITWIDTH = c_DEFAULT_REGADDRBITWIDTH
) (
    input  logic                       clk,
    input  logic                       async_rst,
    input  logic                       clk_en,
    input  logic                       BranchIssue,
    input  logic                       BranchResolveValid,
    input  logic                       BranchMispredicted,
    input  logic                       IssueWriteValid,
    input  logic [REGADDRBITWIDTH-1:0] IssueWriteAddr,
    output logic                       Speculating,
    output logic [REGCOUNT-1:0]        WillBeWritingToA,
    output logic                       EndSpeculationPulse,
    output logic                       MispredictedSpeculationPulse,
    output logic                       IssueStall
`ifdef SPECULATION_PERF_COUNTERS_EN
    ,
    output logic [31:0]                MispredictCount,
    output logic [31:0]                SpecCycleCount
`endif
);

    specState_t r_state;
    specState_t w_nextState;
    logic       w_enterSpec;
    logic       w_setEnd;
    logic       w_setMisp;
    logic       r_endPulse;
    logic       r_mispPulse;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A resolve seen in IDLE or FLUSH is simply ignored.
    always_comb begin
        w_nextState = r_state;
        w_enterSpec = 1'b0;
        w_setEnd    = 1'b0;
        w_setMisp   = 1'b0;
        if (clk_en) begin
            case (r_state)
                IDLE: begin
                    if (BranchIssue) begin
                        w_nextState = SPEC;
                        w_enterSpec = 1'b1;
                    end
                end
                SPEC: begin
                    if (BranchResolveValid) begin
                        if (BranchMispredicted) begin
                            w_nextState = FLUSH;
                            w_setMisp   = 1'b1;
                        end else begin
                            w_nextState = IDLE;
                            w_setEnd    = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Pulses freeze with the rest of the state while clk_en is low.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_endPulse  <= 1'b0;
            r_mispPulse <= 1'b0;
        end else if (clk_en) begin
            r_endPulse  <= w_setEnd;
            r_mispPulse <= w_setMisp;
        end
    end

    assign Speculating                  = (r_state == SPEC);
    assign EndSpeculationPulse          = r_endPulse;
    assign MispredictedSpeculationPulse = r_mispPulse;
    assign IssueStall                   = (r_state == FLUSH)
                                       || ((r_state == SPEC) && BranchIssue);

    SpeculationShadowMask #(
        .REGCOUNT        (REGCOUNT),
        .REGADDRBITWIDTH (REGADDRBITWIDTH)
    ) u_shadowMask (
        .clk                (clk),
        .async_rst          (async_rst),
        .clk_en             (clk_en),
        .inSpec             (r_state == SPEC),
        .clearMask          (w_enterSpec),
        .BranchResolveValid (BranchResolveValid),
        .IssueWriteValid    (IssueWriteValid),
        .IssueWriteAddr     (IssueWriteAddr),
        .WillBeWritingToA   (WillBeWritingToA)
    );

`ifdef SPECULATION_PERF_COUNTERS_EN
    logic [31:0] r_mispredictCount;
    logic [31:0] r_specCycleCount;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            r_mispredictCount <= 32'd0;
            r_specCycleCount  <= 32'd0;
        end else if (clk_en) begin
            if (w_setMisp && (r_mispredictCount != 32'hFFFF_FFFF)) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
            if ((r_state == SPEC) && (r_specCycleCount != 32'hFFFF_FFFF)) begin
                r_specCycleCount <= r_specCycleCount + 32'd1;
            end
        end
    end

    assign MispredictCount = r_mispredictCount;
    assign SpecCycleCount  = r_specCycleCount;
`else
    // Default build carries no performance counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_speculation_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_speculation_controller
// Description : Self-checking bench: directed vector table, reset sequences
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speculation_controller;

    localparam int REGCOUNT = 16;

    logic        clk;
    logic        async_rst;
    logic        clk_en;
    logic        BranchIssue;
    logic        BranchResolveValid;
    logic        BranchMispredicted;
    logic        IssueWriteValid;
    logic [3:0]  IssueWriteAddr;
    logic        Speculating;
    logic [15:0] WillBeWritingToA;
    logic        EndSpeculationPulse;
    logic        MispredictedSpeculationPulse;
    logic        IssueStall;
`ifdef SPECULATION_PERF_COUNTERS_EN
    logic [31:0] MispredictCount;
    logic [31:0] SpecCycleCount;
`endif

    speculation_controller #(
        .REGCOUNT        (16),
        .REGADDRBITWIDTH (4)
    ) dut (
        .clk                          (clk),
        .async_rst                    (async_rst),
        .clk_en                       (clk_en),
        .BranchIssue                  (BranchIssue),
        .BranchResolveValid           (BranchResolveValid),
        .BranchMispredicted           (BranchMispredicted),
        .IssueWriteValid              (IssueWriteValid),
        .IssueWriteAddr               (IssueWriteAddr),
        .Speculating                  (Speculating),
        .WillBeWritingToA             (WillBeWritingToA),
        .EndSpeculationPulse          (EndSpeculationPulse),
        .MispredictedSpeculationPulse (MispredictedSpeculationPulse),
        .IssueStall                   (IssueStall)
`ifdef SPECULATION_PERF_COUNTERS_EN
        ,
        .MispredictCount              (MispredictCount),
        .SpecCycleCount               (SpecCycleCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nFailed   = 0;

    // Behavioural model: a speculation window, a one-cycle flush, and the set
    // of registers already shadowed in the current window.
    bit          mInWindow;
    bit          mFlushing;
    bit          mEnd;
    bit          mMisp;
    bit          mShadowed [int];
    logic [31:0] mSpecCnt;
    logic [31:0] mMispCnt;

    typedef struct {
        bit          ce, bi, brv, bm, wv;
        logic [3:0]  addr;
        bit          eSpec, eStall;
        logic [15:0] eWill;
        bit          eEnd, eMisp;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] modelWill();
        logic [15:0] w;
        w = '0;
        if (mInWindow && IssueWriteValid && !BranchResolveValid
            && (int'(IssueWriteAddr) < REGCOUNT)
            && !mShadowed.exists(int'(IssueWriteAddr)))
            w[IssueWriteAddr] = 1'b1;
        return w;
    endfunction

    function automatic bit modelStall();
        return mFlushing || (mInWindow && BranchIssue);
    endfunction

    task automatic modelReset();
        mInWindow = 0;
        mFlushing = 0;
        mEnd      = 0;
        mMisp     = 0;
        mShadowed.delete();
        mSpecCnt  = 0;
        mMispCnt  = 0;
    endtask

    task automatic drive(input bit ce, input bit bi, input bit brv, input bit bm,
                         input bit wv, input logic [3:0] a);
        clk_en             = ce;
        BranchIssue        = bi;
        BranchResolveValid = brv;
        BranchMispredicted = bm;
        IssueWriteValid    = wv;
        IssueWriteAddr     = a;
        #1;
    endtask

    // Update the model for the coming edge, then let the edge happen.
    task automatic advance();
        logic [15:0] w;
        bit endN, mispN;
        w     = modelWill();
        endN  = 0;
        mispN = 0;
        if (clk_en) begin
            if (mInWindow && mSpecCnt != 32'hFFFF_FFFF) mSpecCnt = mSpecCnt + 1;
            if (mFlushing) begin
                mFlushing = 0;
            end else if (mInWindow) begin
                if (BranchResolveValid) begin
                    mInWindow = 0;
                    if (BranchMispredicted) begin
                        mFlushing = 1;
                        mispN     = 1;
                    end else begin
                        endN = 1;
                    end
                end else begin
                    for (int i = 0; i < REGCOUNT; i++)
                        if (w[i]) mShadowed[i] = 1;
                end
            end else if (BranchIssue) begin
                mInWindow = 1;
                mShadowed.delete();
            end
            mEnd  = endN;
            mMisp = mispN;
            if (mispN && mMispCnt != 32'hFFFF_FFFF) mMispCnt = mMispCnt + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkModel(input string tag);
        check({tag, "_spec"},  Speculating, mInWindow);
        check({tag, "_stall"}, IssueStall, modelStall());
        check({tag, "_will"},  WillBeWritingToA, modelWill());
        check({tag, "_end"},   EndSpeculationPulse, mEnd);
        check({tag, "_misp"},  MispredictedSpeculationPulse, mMisp);
`ifdef SPECULATION_PERF_COUNTERS_EN
        check({tag, "_mispcnt"}, MispredictCount, mMispCnt);
        check({tag, "_speccnt"}, SpecCycleCount, mSpecCnt);
`endif
    endtask

    task automatic step(input bit ce, input bit bi, input bit brv, input bit bm,
                        input bit wv, input logic [3:0] a, input string tag);
        drive(ce, bi, brv, bm, wv, a);
        checkModel(tag);
        advance();
    endtask

    task automatic pulseReset();
        async_rst = 1'b1;
        #1;
        modelReset();
        @(negedge clk);
        async_rst = 1'b0;
    endtask

    initial begin
        //                ce bi brv bm wv addr | spec stall will     end misp
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 4'd2,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd3,   1, 0, 16'h0008, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd3,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd5,   1, 0, 16'h0020, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd2,   1, 0, 16'h0004, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 1, 4'd6,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd7,   1, 0, 16'h0080, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 4'd0,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 4'd7,   0, 1, 16'h0000, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd7,   1, 0, 16'h0080, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'd0,   1, 1, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 4'd0,   1, 1, 16'h0000, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0, 4'd0,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'd9,   1, 0, 16'h0200, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd9,   1, 0, 16'h0200, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 4'd9,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 4'd0,   1, 0, 16'h0000, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'd0,   0, 0, 16'h0000, 0, 0});

        async_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 4'd0);
        modelReset();
        #1;
        check("rst_spec",  Speculating, 1'b0);
        check("rst_stall", IssueStall, 1'b0);
        check("rst_will",  WillBeWritingToA, 16'h0000);
        check("rst_end",   EndSpeculationPulse, 1'b0);
        check("rst_misp",  MispredictedSpeculationPulse, 1'b0);
        @(negedge clk);
        async_rst = 1'b0;
        @(negedge clk);

        foreach (tbl[k]) begin
            drive(tbl[k].ce, tbl[k].bi, tbl[k].brv, tbl[k].bm, tbl[k].wv, tbl[k].addr);
            check($sformatf("vec%0d_spec", k),  Speculating, tbl[k].eSpec);
            check($sformatf("vec%0d_stall", k), IssueStall, tbl[k].eStall);
            check($sformatf("vec%0d_will", k),  WillBeWritingToA, tbl[k].eWill);
            check($sformatf("vec%0d_end", k),   EndSpeculationPulse, tbl[k].eEnd);
            check($sformatf("vec%0d_misp", k),  MispredictedSpeculationPulse, tbl[k].eMisp);
            advance();
        end

        // Reset between edges while speculating, with clk_en low.
        pulseReset();
        step(1, 1, 0, 0, 0, 4'd0, "rs_issue");
        step(1, 0, 0, 0, 1, 4'd4, "rs_write");
        drive(0, 0, 0, 0, 0, 4'd0);
        check("rs_pre_spec", Speculating, 1'b1);
        #2;
        async_rst = 1'b1;
        #1;
        check("rs_mid_spec",  Speculating, 1'b0);
        check("rs_mid_stall", IssueStall, 1'b0);
        modelReset();
        @(negedge clk);
        async_rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1, 0, 1, i[0], 0, 4'd0, "rs_after");

        // Reset while flushing kills the pending restore pulse.
        step(1, 1, 0, 0, 0, 4'd0, "rf_issue");
        step(1, 0, 1, 1, 0, 4'd0, "rf_mispredict");
        drive(1, 0, 0, 0, 0, 4'd0);
        check("rf_pre_misp",  MispredictedSpeculationPulse, 1'b1);
        check("rf_pre_stall", IssueStall, 1'b1);
        #2;
        async_rst = 1'b1;
        #1;
        check("rf_mid_misp",  MispredictedSpeculationPulse, 1'b0);
        check("rf_mid_stall", IssueStall, 1'b0);
        modelReset();
        @(negedge clk);
        async_rst = 1'b0;
        step(1, 0, 0, 0, 0, 4'd0, "rf_after");

`ifdef SPECULATION_PERF_COUNTERS_EN
        pulseReset();
        step(1, 1, 0, 0, 0, 4'd0, "pc_issue");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 4'd0, "pc_spec");
        step(1, 0, 1, 1, 0, 4'd0, "pc_mispredict");
        check("pc_speccnt", SpecCycleCount, 32'd5);
        check("pc_mispcnt", MispredictCount, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 4'd0, "pc_frozen");
        check("pc_speccnt_frozen", SpecCycleCount, 32'd5);
        check("pc_mispcnt_frozen", MispredictCount, 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 60),
                 4'($urandom_range(0, 15)),
                 "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
`default_nettype wire
